dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder serving the pipeline's memory-access stage over a valid/ready request/response pair.
//  Executes byte/half/word loads and stores from a word-organised array, with programmable access latency.
//  Owns load sign/zero extension and store lane steering; the pipeline only presents address, size and data.
//  Sits between the MEM stage and the on-chip RAM array; one outstanding transaction at a time.
// PARAMETERS
//  ADDR_W   10  word-address bits; array holds 2**ADDR_W 32-bit words
//  LATENCY  2   clock edges from request accept edge to rsp_valid rising (legal 1..15)
// PORTS
//  clk           in   1   rising-edge clock, single clock domain
//  rst           in   1   asynchronous, active-high reset
//  req_valid     in   1   request present
//  req_ready     out  1   responder can accept (IDLE only)
//  req_we        in   1   1 = store, 0 = load
//  req_addr      in   32  byte address; bits [ADDR_W+1:2] index array, upper bits ignored (aliasing)
//  req_size      in   2   0 byte, 1 half, 2 word; 3 treated as word
//  req_unsigned  in   1   loads: 1 zero-extend, 0 sign-extend
//  req_wdata     in   32  store data, right-justified (lane 0)
//  rsp_valid     out  1   response present
//  rsp_ready     in   1   pipeline accepts response
//  rsp_rdata     out  32  extended load data; 0 for stores
//  rsp_err       out  1   misaligned-access error (see CONFIGURATION)
// BEHAVIOUR
//  Reset is asynchronous and active-high on rst: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
//  The array is not reset; contents survive rst.
//  FSM IDLE -> BUSY on req_valid&req_ready; request fields are captured on that edge; counter loads LATENCY-1.
//  BUSY: counter decrements each edge; at 0 the next edge goes to RESP.
//  On that same edge a store commits and load data is registered.
//  RESP: rsp_valid=1, outputs held stable until rsp_valid&rsp_ready; that edge returns to IDLE.
//  req_ready=0 in BUSY and RESP; no same-cycle accept on response handshake.
//  Minimum request-to-request spacing is therefore LATENCY+2 edges.
//  Store lanes:
//   - byte writes lane addr[1:0];
//   - half writes lanes {addr[1],0} and {addr[1],1};
//   - word writes all 4 lanes.
//   - Non-written lanes are unchanged.
//  Load: select lane(s) as for stores, then extend per req_unsigned to 32 bits; word ignores req_unsigned.
//  Store response: rsp_rdata=0, rsp_err=0 (unless misaligned, see below).
//  Reset asserted in BUSY/RESP: transaction aborted.
//   - If reset lands before the commit edge, the store does not occur.
//   - No response is produced.
//  req_* changes while not accepted are ignored; rsp_ready while rsp_valid=0 is ignored.
// CONFIGURATION
//  Macro DMEM_MISALIGN_ERR_EN.
//  Defined:
//   - half with addr[0]=1, or word with addr[1:0]!=0, is misaligned;
//   - misaligned stores write nothing;
//   - misaligned loads return rsp_rdata=0;
//   - rsp_err=1 in RESP; timing is unchanged.
//  Undefined:
//   - misaligned low address bits are forced to 0 (half clears bit0, word clears bits1:0);
//   - rsp_err is tied 0.
// STRUCTURE
//  Package rv_mem_pkg:
//   - size localparams SZ_B=0, SZ_H=1, SZ_W=2;
//   - FSM state encodings IDLE/BUSY/RESP;
//   - function load_extend(word, addr_lo, size, unsigned).
//  Sub-module dmem_lane_align (combinational):
//   - inputs addr[1:0], size, wdata;
//   - produces 4-bit byte-enable and lane-replicated write data.
//  The top level holds the FSM, counter, capture registers and array.
// TESTING
//  1 Word round trip: store 0xDEADBEEF @0x10; load word @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
//  2 Byte extend: mem@0x20=0x80FF7F01; lb @0x23 -> 0xFFFFFF80; lbu @0x23 -> 0x00000080; lb @0x20 -> 0x00000001.
//  3 Half store lanes: word@0x30=0x11223344; sh 0xABCD @0x32; lw @0x30 -> 0xABCD3344.
//    Then lh @0x32 -> 0xFFFFABCD.
//  4 Latency/backpressure: LATENCY=3; rsp_valid rises exactly 3 edges after accept.
//    Hold rsp_ready=0 5 cycles -> outputs stable, req_ready=0 throughout.
//  5 Reset mid-flight: accept store 0x12345678 @0x40, assert rst in BUSY.
//    Expect rsp_valid=0, req_ready=1 after release; lw @0x40 returns prior value.
//  6 Misaligned lw @0x41: with DMEM_MISALIGN_ERR_EN -> rsp_err=1, rdata=0, no write.
//    Without it -> reads word @0x40, rsp_err=0.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared definitions for the data-memory responder.
//   - access size encodings (SZ_B / SZ_H / SZ_W; encoding 3 is normalised to SZ_W)
//   - FSM state encoding (IDLE / BUSY / RESP)
//   - load_extend(): selects the byte/half lane of a 32-bit word and extends it
package rv_mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Pick the addressed lane(s) and sign/zero extend; words ignore is_unsigned.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  addr_lo,
                                              input logic [1:0]  size,
                                              input logic        is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (addr_lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    r = is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_H:    r = is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Store lane steering for the data-memory responder (purely combinational).
// Ports:
//   addr_lo_i [1:0]  low byte-address bits (already forced/aligned by caller)
//   size_i    [1:0]  access size (SZ_B/SZ_H/SZ_W)
//   wdata_i   [31:0] right-justified store data
//   be_o      [3:0]  byte enables
//   wdata_o   [31:0] store data replicated across lanes
module dmem_lane_align
  import rv_mem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);

  // Byte-enable and lane-replicated data generation.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    case (size_i)
      SZ_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_H: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store engine with programmable
// latency over valid/ready request and response channels.
// Ports:
//   clk, rst (async, active-high)
//   req_valid/req_ready, req_we, req_addr[31:0], req_size[1:0], req_unsigned, req_wdata[31:0]
//   rsp_valid/rsp_ready, rsp_rdata[31:0], rsp_err
// Configuration macro: DMEM_MISALIGN_ERR_EN
//   defined   - misaligned half/word accesses flag rsp_err, write nothing, read 0
//   undefined - misaligned low address bits are forced to 0, rsp_err stays 0
module dmem_responder
  import rv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem_q [2**ADDR_W];

  logic [ADDR_W-1:0] idx_s;
  logic [1:0]        addr_lo_s;
  logic              misalign_s;
  logic [3:0]        be_s;
  logic [31:0]       wdata_rep_s;
  logic [31:0]       rd_word_s;
  logic              commit_s;
  logic              unused_addr_s;

  assign unused_addr_s = ^req_addr[31:ADDR_W+2];
  assign idx_s         = addr_q[ADDR_W+1:2];
  assign rd_word_s     = mem_q[idx_s];

`ifdef DMEM_MISALIGN_ERR_EN
  assign misalign_s = ((size_q == SZ_H) && addr_q[0]) ||
                      ((size_q == SZ_W) && (addr_q[1:0] != 2'b00));
  assign addr_lo_s  = addr_q[1:0];
`else
  assign misalign_s = 1'b0;
  // Alias misaligned accesses down to the naturally aligned lane.
  assign addr_lo_s  = (size_q == SZ_H) ? {addr_q[1], 1'b0} :
                      (size_q == SZ_W) ? 2'b00 : addr_q[1:0];
`endif

  dmem_lane_align u_lane_align (
    .addr_lo_i (addr_lo_s),
    .size_i    (size_q),
    .wdata_i   (wdata_q),
    .be_o      (be_s),
    .wdata_o   (wdata_rep_s)
  );

  // The BUSY->RESP edge is the commit point; reset in flight cancels it.
  assign commit_s = (state_q == BUSY) && (cnt_q == 4'd0) && we_q && !misalign_s && !rst;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Next-state, capture and response data logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
          we_d    = req_we;
          addr_d  = req_addr[ADDR_W+1:0];
          size_d  = (req_size == 2'd3) ? SZ_W : req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          rdata_d = (we_q || misalign_s) ? 32'd0
                                         : load_extend(rd_word_s, addr_lo_s, size_q, uns_q);
          err_d   = misalign_s;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control, capture and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array; deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_q[idx_s][8*i +: 8] <= wdata_rep_s[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=3).
// Honours DMEM_MISALIGN_ERR_EN for the misaligned-access expectations.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd;
  logic        er;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .LATENCY(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full transaction; 'hold' cycles of response backpressure with noisy requests.
  task automatic transact(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata, input int hold,
                          output logic [31:0] rdata, output logic err);
    int edges;
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
    edges = 0;
    while (!rsp_valid && edges < 20) begin
      check("req_ready_busy", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      edges++;
    end
    check("latency", 32'(edges), 32'd3);
    rdata = rsp_rdata;
    err   = rsp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0010;
      req_size = 2'd2; req_wdata = 32'hBAD0_BAD0;
      @(posedge clk); #1;
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_rdata", rsp_rdata, rdata);
      check("bp_err",   32'(rsp_err), 32'(err));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = 32'd0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Word round trip
    transact(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 0, rd, er);
    check("sw_rdata", rd, 32'd0);
    check("sw_err", 32'(er), 32'd0);
    transact(1'b0, 32'h10, 2'd2, 1'b0, 32'd0, 0, rd, er);
    check("lw_10", rd, 32'hDEADBEEF);
    check("lw_10_err", 32'(er), 32'd0);

    // Byte extension
    transact(1'b1, 32'h20, 2'd2, 1'b0, 32'h80FF7F01, 0, rd, er);
    transact(1'b0, 32'h23, 2'd0, 1'b0, 32'd0, 0, rd, er);
    check("lb_23", rd, 32'hFFFFFF80);
    transact(1'b0, 32'h23, 2'd0, 1'b1, 32'd0, 0, rd, er);
    check("lbu_23", rd, 32'h00000080);
    transact(1'b0, 32'h20, 2'd0, 1'b0, 32'd0, 0, rd, er);
    check("lb_20", rd, 32'h00000001);

    // Half / byte store lanes
    transact(1'b1, 32'h30, 2'd2, 1'b0, 32'h11223344, 0, rd, er);
    transact(1'b1, 32'h32, 2'd1, 1'b0, 32'h0000ABCD, 0, rd, er);
    transact(1'b0, 32'h30, 2'd2, 1'b0, 32'd0, 0, rd, er);
    check("lw_30_sh", rd, 32'hABCD3344);
    transact(1'b0, 32'h32, 2'd1, 1'b0, 32'd0, 0, rd, er);
    check("lh_32", rd, 32'hFFFFABCD);
    transact(1'b1, 32'h31, 2'd0, 1'b0, 32'hFFFFFF5A, 0, rd, er);
    transact(1'b0, 32'h30, 2'd3, 1'b0, 32'd0, 0, rd, er);
    check("lw_30_sb", rd, 32'hABCD5A44);
    transact(1'b0, 32'h30, 2'd1, 1'b1, 32'd0, 0, rd, er);
    check("lhu_30", rd, 32'h00005A44);

    // Backpressure: 5 stalled cycles with noise on the request side
    transact(1'b0, 32'h30, 2'd2, 1'b0, 32'd0, 5, rd, er);
    check("bp_lw_30", rd, 32'hABCD5A44);
    transact(1'b0, 32'h10, 2'd2, 1'b0, 32'd0, 0, rd, er);
    check("bp_no_accept", rd, 32'hDEADBEEF);

    // Aliasing: upper address bits ignored
    transact(1'b0, 32'h8000_1010, 2'd2, 1'b0, 32'd0, 0, rd, er);
    check("alias_lw", rd, 32'hDEADBEEF);

    // Reset mid-flight aborts a store
    transact(1'b1, 32'h40, 2'd2, 1'b0, 32'hCAFEF00D, 0, rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_size = 2'd2; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_valid", 32'(rsp_valid), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    transact(1'b0, 32'h40, 2'd2, 1'b0, 32'd0, 0, rd, er);
    check("abort_lw_40", rd, 32'hCAFEF00D);

    // Misaligned accesses
    transact(1'b0, 32'h41, 2'd2, 1'b0, 32'd0, 0, rd, er);
`ifdef DMEM_MISALIGN_ERR_EN
    check("mis_lw_rdata", rd, 32'd0);
    check("mis_lw_err", 32'(er), 32'd1);
`else
    check("mis_lw_rdata", rd, 32'hCAFEF00D);
    check("mis_lw_err", 32'(er), 32'd0);
`endif
    transact(1'b1, 32'h42, 2'd2, 1'b0, 32'h99999999, 0, rd, er);
    transact(1'b0, 32'h40, 2'd2, 1'b0, 32'd0, 0, rd, er);
`ifdef DMEM_MISALIGN_ERR_EN
    check("mis_sw_nowrite", rd, 32'hCAFEF00D);
`else
    check("mis_sw_forced", rd, 32'h99999999);
`endif
    check("aligned_err", 32'(er), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
